// File: rtl/instr_sequencer.sv
// Instruction sequencer: small imem + PC, issues one instruction every 3 cycles
// (FETCH/DECODE/EXEC) as register/ALU controls for the downstream datapath.
module instr_sequencer #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 12
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               load_en,
  input  logic [PC_W-1:0]    load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               zero_flag,
  output logic [1:0]         read_reg_num1,
  output logic [1:0]         read_reg_num2,
  output logic [1:0]         write_reg,
  output logic [2:0]         alu_control,
  output logic               regwrite,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               halted
);

  localparam int DEPTH = 1 << PC_W;
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  localparam logic [1:0] T_ALU  = 2'b00;
  localparam logic [1:0] T_BZ   = 2'b01;
  localparam logic [1:0] T_HALT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALTED
  } state_t;

  state_t             state;
  logic [INSTR_W-1:0] imem [DEPTH];
  logic [INSTR_W-1:0] ir;
  logic [1:0]         ir_type;
  logic [PC_W-1:0]    bz_target;
  logic               quiescent;

  assign ir_type   = ir[11:10];
  assign bz_target = ir[PC_W-1:0];
  assign quiescent = (state == S_IDLE) || (state == S_HALTED);

  // Program memory is deliberately left out of reset so a reloaded program survives it.
  always_ff @(posedge clock) begin
    if (load_en && quiescent)
      imem[load_addr] <= load_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      pc            <= '0;
      ir            <= '0;
      read_reg_num1 <= '0;
      read_reg_num2 <= '0;
      write_reg     <= '0;
      alu_control   <= '0;
      regwrite      <= 1'b0;
      busy          <= 1'b0;
      halted        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state  <= S_FETCH;
            pc     <= '0;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        S_FETCH: begin
          ir    <= imem[pc];
          state <= S_DECODE;
        end
        S_DECODE: begin
          // Fields stay put through EXEC so a BZ compare settles before zero_flag is sampled.
          alu_control   <= ir[9:7];
          read_reg_num1 <= ir[6:5];
          read_reg_num2 <= ir[4:3];
          write_reg     <= ir[2:1];
          regwrite      <= (ir_type == T_ALU);
          state         <= S_EXEC;
        end
        S_EXEC: begin
          regwrite <= 1'b0;
          state    <= S_FETCH;
          case (ir_type)
            T_BZ:    pc <= zero_flag ? bz_target : pc + PC_ONE;
            T_HALT: begin
              state  <= S_HALTED;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
            default: pc <= pc + PC_ONE;
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
